// File: rtl/temp_buffer_xp.sv
// Square MAC_NUM x MAC_NUM scratch buffer: masked/accumulating row writes, registered row or column reads,
// and a sequential clear sweep. Define TEMP_BUFFER_XP_ACC_EN to compile in the per-lane accumulate adders.

module temp_buffer_xp_lane #(
    parameter int ELEM_WIDTH = 8
) (
    input  logic [ELEM_WIDTH-1:0] cur,
    input  logic [ELEM_WIDTH-1:0] din,
    input  logic                  acc,
    output logic [ELEM_WIDTH-1:0] nxt
);
    // Sum truncates to ELEM_WIDTH, giving two's-complement wrap.
    assign nxt = acc ? ELEM_WIDTH'(cur + din) : din;
endmodule

module temp_buffer_xp #(
    parameter int MAC_NUM    = 8,
    parameter int ELEM_WIDTH = 8,
    parameter int DATA_WIDTH = MAC_NUM * ELEM_WIDTH,
    parameter int ADDR_WIDTH = $clog2(MAC_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    output logic                  busy_o,
    input  logic                  wr_en_i,
    input  logic                  wr_acc_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [MAC_NUM-1:0]    wr_mask_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic                  rd_col_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o
);
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    logic                               state;
    logic [ADDR_WIDTH-1:0]              clr_cnt;
    logic [MAC_NUM-1:0][DATA_WIDTH-1:0] mem;
    logic [DATA_WIDTH-1:0]              upd_row;
    logic [DATA_WIDTH-1:0]              col_data;

    assign busy_o = (state == ST_CLEAR);

`ifdef TEMP_BUFFER_XP_ACC_EN
    logic [DATA_WIDTH-1:0] wr_row;
    assign wr_row = mem[wr_addr_i];

    for (genvar k = 0; k < MAC_NUM; k++) begin : g_lane
        temp_buffer_xp_lane #(.ELEM_WIDTH(ELEM_WIDTH)) u_lane (
            .cur (wr_row[k*ELEM_WIDTH +: ELEM_WIDTH]),
            .din (wr_data_i[k*ELEM_WIDTH +: ELEM_WIDTH]),
            .acc (wr_acc_i),
            .nxt (upd_row[k*ELEM_WIDTH +: ELEM_WIDTH])
        );
    end
`else
    logic unused_acc;
    assign unused_acc = wr_acc_i;
    assign upd_row    = wr_data_i;
`endif

    // Column gather: lane r of the result is element (r, rd_addr_i).
    always_comb begin
        col_data = '0;
        for (int r = 0; r < MAC_NUM; r++) begin
            for (int c = 0; c < MAC_NUM; c++) begin
                if (ADDR_WIDTH'(c) == rd_addr_i)
                    col_data[r*ELEM_WIDTH +: ELEM_WIDTH] = mem[r][c*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            mem        <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_en_i) begin
                        for (int k = 0; k < MAC_NUM; k++) begin
                            if (wr_mask_i[k])
                                mem[wr_addr_i][k*ELEM_WIDTH +: ELEM_WIDTH] <= upd_row[k*ELEM_WIDTH +: ELEM_WIDTH];
                        end
                    end
                    // Read samples pre-write contents since mem updates only at this edge.
                    if (rd_en_i) begin
                        rd_valid_o <= 1'b1;
                        rd_data_o  <= rd_col_i ? col_data : mem[rd_addr_i];
                    end
                    if (clr_i) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    mem[clr_cnt] <= '0;
                    clr_cnt      <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_WIDTH'(MAC_NUM - 1))
                        state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
